// File: rtl/cpu_defs.sv
// Shared encodings for the ALU, ALU control decode and the ID/EX stage.
package cpu_defs;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_NOP = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_control.sv
// Combinational ALUOp/funct decode to the 3-bit ALU control plus an
// unsupported-funct flag.
module alu_control
  import cpu_defs::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_OR:  ctrl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          default:   illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, applies the ALUSrc/RegDst
// muxes and holds the result for EX, with stall hold and flush bubbles.
module id_ex_stage
  import cpu_defs::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [5:0]    id_funct,
  input  logic [1:0]    id_aluop,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_regwrite,
  output logic          ex_valid,
  output logic [DW-1:0] ex_alu_a,
  output logic [DW-1:0] ex_alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [2:0]    ex_alu_ctrl,
  output logic [RW-1:0] ex_wreg,
  output logic [DW-1:0] ex_pc4,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_regwrite,
  output logic          ex_illegal
);

  logic [2:0] dec_ctrl;
  logic       dec_illegal;
  logic       is_nop;
  logic       is_illegal;
  logic       bubble;

  alu_control u_alu_control (
    .aluop   (id_aluop),
    .funct   (id_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // funct 0 is not a supported ALU op, so the NOP case must mask the illegal flag
  assign is_nop     = (id_aluop == ALUOP_RTYPE) && (id_funct == FUNCT_NOP) && (id_rd == '0);
  assign is_illegal = id_valid && dec_illegal && !is_nop;
  assign bubble     = flush || !id_valid || dec_illegal || is_nop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_alu_a      <= '0;
      ex_alu_b      <= '0;
      ex_store_data <= '0;
      ex_alu_ctrl   <= ALU_ADD;
      ex_wreg       <= '0;
      ex_pc4        <= '0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_memtoreg   <= 1'b0;
      ex_regwrite   <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (flush || !stall) begin
      ex_illegal <= !flush && is_illegal;
      if (bubble) begin
        ex_valid      <= 1'b0;
        ex_alu_a      <= '0;
        ex_alu_b      <= '0;
        ex_store_data <= '0;
        ex_alu_ctrl   <= ALU_ADD;
        ex_wreg       <= '0;
        ex_pc4        <= '0;
        ex_memread    <= 1'b0;
        ex_memwrite   <= 1'b0;
        ex_memtoreg   <= 1'b0;
        ex_regwrite   <= 1'b0;
      end else begin
        ex_valid      <= 1'b1;
        ex_alu_a      <= id_rs_data;
        ex_alu_b      <= id_alusrc ? id_imm : id_rt_data;
        ex_store_data <= id_rt_data;
        ex_alu_ctrl   <= dec_ctrl;
        ex_wreg       <= id_regdst ? id_rd : id_rt;
        ex_pc4        <= id_pc4;
        ex_memread    <= id_memread;
        ex_memwrite   <= id_memwrite;
        ex_memtoreg   <= id_memtoreg;
        ex_regwrite   <= id_regwrite;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a table-driven reference model.
module tb_id_ex_stage;

  logic        clk, rst, stall, flush, id_valid;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_memread, id_memwrite, id_memtoreg, id_regwrite;
  logic        ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_illegal;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc4;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_wreg;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_wreg(ex_wreg),
    .ex_pc4(ex_pc4), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic        m_valid, m_mr, m_mw, m_mt, m_rw, m_ill;
  logic [31:0] m_a, m_b, m_store, m_pc4;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_wreg;

  int funct_tab [5] = '{32, 34, 36, 37, 42};
  int ctrl_tab  [5] = '{2, 6, 0, 1, 7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_bubble(input logic ill);
    m_valid = 0; m_a = 0; m_b = 0; m_store = 0; m_ctrl = 3'd2; m_wreg = 0; m_pc4 = 0;
    m_mr = 0; m_mw = 0; m_mt = 0; m_rw = 0; m_ill = ill;
  endtask

  // what the register should hold after a clock edge with the current inputs
  task automatic model_edge();
    int  c;
    bit  found;
    if (flush) model_bubble(0);
    else if (stall) ;
    else if (!id_valid) model_bubble(0);
    else begin
      found = 1;
      c = 2;
      if (id_aluop == 2'd1) c = 6;
      else if (id_aluop == 2'd3) c = 1;
      else if (id_aluop == 2'd2) begin
        found = 0;
        for (int i = 0; i < 5; i++)
          if (int'(id_funct) == funct_tab[i]) begin found = 1; c = ctrl_tab[i]; end
      end
      if (id_aluop == 2'd2 && id_funct == 0 && id_rd == 0) model_bubble(0);
      else if (!found) model_bubble(1);
      else begin
        m_valid = 1; m_a = id_rs_data; m_b = id_alusrc ? id_imm : id_rt_data;
        m_store = id_rt_data; m_ctrl = c[2:0]; m_wreg = id_regdst ? id_rd : id_rt;
        m_pc4 = id_pc4; m_mr = id_memread; m_mw = id_memwrite; m_mt = id_memtoreg;
        m_rw = id_regwrite; m_ill = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    ex_valid,      m_valid);
    chk({tag, ".alu_a"},    ex_alu_a,      m_a);
    chk({tag, ".alu_b"},    ex_alu_b,      m_b);
    chk({tag, ".store"},    ex_store_data, m_store);
    chk({tag, ".ctrl"},     ex_alu_ctrl,   m_ctrl);
    chk({tag, ".wreg"},     ex_wreg,       m_wreg);
    chk({tag, ".pc4"},      ex_pc4,        m_pc4);
    chk({tag, ".memread"},  ex_memread,    m_mr);
    chk({tag, ".memwrite"}, ex_memwrite,   m_mw);
    chk({tag, ".memtoreg"}, ex_memtoreg,   m_mt);
    chk({tag, ".regwrite"}, ex_regwrite,   m_rw);
    chk({tag, ".illegal"},  ex_illegal,    m_ill);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // called just after a check (posedge+1): pulses rst between edges
  task automatic reset_pulse(input string tag);
    #2 rst = 1;
    #1 model_bubble(0);
    check_all(tag);
    #1 rst = 0;
  endtask

  task automatic clr_inputs();
    stall = 0; flush = 0; id_valid = 1;
    id_pc4 = $urandom; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rt = 0; id_rd = 0; id_funct = 0; id_aluop = 0;
    id_alusrc = 0; id_regdst = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0; id_regwrite = 0;
  endtask

  task automatic rand_instr();
    int r;
    id_valid = $urandom_range(0, 7) != 0;
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rt = 5'($urandom); id_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    id_aluop = 2'($urandom);
    r = $urandom_range(0, 9);
    if (r < 5) id_funct = 6'(funct_tab[r]);
    else if (r == 5) id_funct = 0;
    else id_funct = 6'($urandom);
    id_alusrc = 1'($urandom); id_regdst = 1'($urandom);
    id_memread = 1'($urandom); id_memwrite = 1'($urandom);
    id_memtoreg = 1'($urandom); id_regwrite = 1'($urandom);
  endtask

  initial begin
    rst = 0;
    clr_inputs();
    #1 rst = 1;
    #1 model_bubble(0);
    check_all("reset");
    chk("reset_ctrl", ex_alu_ctrl, 3'b010);
    #10 rst = 0;

    // R-type sub
    clr_inputs();
    id_aluop = 2'b10; id_funct = 6'b100010; id_rs_data = 7; id_rt_data = 3;
    id_regdst = 1; id_rd = 9; id_rt = 2; id_regwrite = 1;
    tick("sub");
    chk("sub_ctrl", ex_alu_ctrl, 3'b110);
    chk("sub_wreg", ex_wreg, 5'd9);

    // lw
    clr_inputs();
    id_aluop = 2'b00; id_alusrc = 1; id_imm = 32'hFFFF_FFFC; id_rt = 4; id_rd = 11;
    id_rs_data = 32'h100; id_rt_data = 32'h55; id_memread = 1; id_memtoreg = 1; id_regwrite = 1;
    tick("lw");
    chk("lw_b", ex_alu_b, 32'hFFFF_FFFC);
    chk("lw_wreg", ex_wreg, 5'd4);

    // illegal funct, then its pulse must drop
    clr_inputs();
    id_aluop = 2'b10; id_funct = 6'b000111; id_rd = 5; id_rs_data = 1; id_regwrite = 1;
    tick("illegal");
    chk("illegal_flag", ex_illegal, 1'b1);
    clr_inputs();
    id_aluop = 2'b10; id_funct = 6'b000000; id_rd = 0; id_rt = 3; id_regwrite = 1;
    tick("nop");
    chk("nop_flag", ex_illegal, 1'b0);
    chk("nop_valid", ex_valid, 1'b0);

    // slt then a 3-cycle stall with changing inputs
    clr_inputs();
    id_aluop = 2'b10; id_funct = 6'b101010; id_rs_data = 20; id_rt_data = 30;
    id_regdst = 1; id_rd = 12; id_regwrite = 1;
    tick("slt");
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      stall = 1; flush = 0;
      tick("stall");
      chk("stall_ctrl", ex_alu_ctrl, 3'b111);
    end
    stall = 1; flush = 1;
    tick("stall_flush");
    chk("stall_flush_valid", ex_valid, 1'b0);

    // illegal held across a stall
    clr_inputs();
    id_aluop = 2'b10; id_funct = 6'b111111;
    tick("ill2");
    stall = 1; rand_instr();
    tick("ill_hold");
    chk("ill_hold_flag", ex_illegal, 1'b1);

    // sw, async reset mid-cycle, then beq after release
    clr_inputs();
    id_aluop = 2'b00; id_alusrc = 1; id_imm = 8; id_rs_data = 32'h200; id_rt_data = 32'hABCD;
    id_rt = 6; id_memwrite = 1;
    tick("sw");
    reset_pulse("rst_mid");
    chk("rst_mid_ctrl", ex_alu_ctrl, 3'b010);
    clr_inputs();
    id_aluop = 2'b01; id_rs_data = 5; id_rt_data = 5; id_rt = 1;
    tick("beq");
    chk("beq_ctrl", ex_alu_ctrl, 3'b110);
    chk("beq_memwrite", ex_memwrite, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_instr();
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      tick("rand");
      if ($urandom_range(0, 39) == 0) reset_pulse("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
